// File: rtl/mips_run_monitor.sv
// Run-control monitor beside the MIPS core: detects a PC halt loop or cycle-budget timeout, then streams PC and RF contents.
// Optional MON_SKIP_ZERO_EN: registers reading zero are skipped during the register dump.
module mips_run_monitor #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned HALT_CYC = 4,
  parameter int unsigned MAX_CYC  = 65535,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PC_W-1:0]   pc,
  output logic [IDX_W-1:0]  rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [IDX_W-1:0]  dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int unsigned      ST_W      = $clog2(HALT_CYC) + 1;
  localparam logic [ST_W-1:0]  HALT_LAST = ST_W'(HALT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_CYC - 1);
  localparam logic [IDX_W-1:0] PC_IDX    = IDX_W'(NUM_REGS);
  localparam logic [IDX_W-1:0] REG_LAST  = IDX_W'(NUM_REGS - 1);
`ifdef MON_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RUN, DUMP_PC, DUMP_REG, FINISH} state_t;

  state_t            state, state_d;
  logic [ST_W-1:0]   stable, stable_d;
  logic [PC_W-1:0]   prev_pc, prev_pc_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [IDX_W-1:0]  addr_d, idx_d;
  logic [DATA_W-1:0] data_d;
  logic              valid_d, busy_d, done_d, timeout_d;
  logic              pc_same, run_end, rd_zero;

  assign pc_same = (pc == prev_pc);
  assign rd_zero = SKIP_ZERO && (rf_rd_data == '0);

  // rf_rd_addr runs one index ahead of dump_idx so the next beat loads on the transfer edge
  always_comb begin
    state_d   = state;
    stable_d  = stable;
    prev_pc_d = prev_pc;
    cnt_d     = cycle_count;
    addr_d    = rf_rd_addr;
    idx_d     = dump_idx;
    data_d    = dump_data;
    valid_d   = dump_valid;
    busy_d    = busy;
    done_d    = done;
    timeout_d = timeout;
    run_end   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_d     = '0;
          stable_d  = '0;
          prev_pc_d = pc;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          addr_d    = '0;
        end
      end
      RUN: begin
        if (cycle_count != '1) cnt_d = cycle_count + CNT_W'(1);
        if (pc_same) begin
          stable_d = stable + ST_W'(1);
        end else begin
          stable_d  = '0;
          prev_pc_d = pc;
        end
        // halt wins over timeout when both land on the same cycle
        if (pc_same && (stable == HALT_LAST)) begin
          run_end   = 1'b1;
          timeout_d = 1'b0;
        end else if (cycle_count == CNT_LAST) begin
          run_end   = 1'b1;
          timeout_d = 1'b1;
        end
        if (run_end) begin
          state_d = DUMP_PC;
          valid_d = 1'b1;
          idx_d   = PC_IDX;
          data_d  = DATA_W'(prev_pc_d);
          addr_d  = '0;
        end
      end
      DUMP_PC, DUMP_REG: begin
        if (!dump_valid || dump_ready) begin
          if ((rf_rd_addr == PC_IDX) || (rd_zero && (rf_rd_addr == REG_LAST))) begin
            state_d = FINISH;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (rd_zero) begin
            state_d = DUMP_REG;
            valid_d = 1'b0;
            addr_d  = rf_rd_addr + IDX_W'(1);
          end else begin
            state_d = DUMP_REG;
            valid_d = 1'b1;
            idx_d   = rf_rd_addr;
            data_d  = rf_rd_data;
            addr_d  = rf_rd_addr + IDX_W'(1);
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      stable      <= '0;
      prev_pc     <= '0;
      cycle_count <= '0;
      rf_rd_addr  <= '0;
      dump_idx    <= '0;
      dump_data   <= '0;
      dump_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_d;
      stable      <= stable_d;
      prev_pc     <= prev_pc_d;
      cycle_count <= cnt_d;
      rf_rd_addr  <= addr_d;
      dump_idx    <= idx_d;
      dump_data   <= data_d;
      dump_valid  <= valid_d;
      busy        <= busy_d;
      done        <= done_d;
      timeout     <= timeout_d;
    end
  end

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor: a scoreboard queue of expected dump beats checked at each valid cycle.
module tb_mips_run_monitor;

  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] data;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        a_start, a_valid, a_ready, a_busy, a_done, a_timeout;
  logic [31:0] a_pc, a_rdata, a_data, a_cc;
  logic [7:0]  a_addr, a_idx;
  logic        b_start, b_valid, b_ready, b_busy, b_done, b_timeout;
  logic [31:0] b_pc, b_rdata, b_data, b_cc;
  logic [7:0]  b_addr, b_idx;
  logic [31:0] rf [32];

  int    total = 0;
  int    bad   = 0;
  beat_t q[$];

  assign a_rdata = (a_addr < 8'd32) ? rf[a_addr[4:0]] : 32'h0;
  assign b_rdata = (b_addr < 8'd32) ? rf[b_addr[4:0]] : 32'h0;

  mips_run_monitor #(.MAX_CYC(100)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .pc(a_pc),
    .rf_rd_addr(a_addr), .rf_rd_data(a_rdata),
    .dump_valid(a_valid), .dump_ready(a_ready), .dump_idx(a_idx), .dump_data(a_data),
    .busy(a_busy), .done(a_done), .timeout(a_timeout), .cycle_count(a_cc)
  );

  mips_run_monitor #(.MAX_CYC(4), .HALT_CYC(4)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .pc(b_pc),
    .rf_rd_addr(b_addr), .rf_rd_data(b_rdata),
    .dump_valid(b_valid), .dump_ready(b_ready), .dump_idx(b_idx), .dump_data(b_data),
    .busy(b_busy), .done(b_done), .timeout(b_timeout), .cycle_count(b_cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [7:0] idx, input logic [31:0] data);
    beat_t e;
    e.idx  = idx;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic push_full(input logic [31:0] pcval);
    q.delete();
    push_beat(8'd32, pcval);
    for (int i = 0; i < 32; i++) push_beat(8'(i), rf[i]);
  endtask

  task automatic fill_rf();
    for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 + 32'(i * 17) + 32'h1;
  endtask

  // Consume beats until done; every valid cycle must present the scoreboard head.
  task automatic drain_a(input string tag, input bit stall, input int max_cyc,
                         output int nxfer, output int nvalid);
    beat_t e;
    nxfer  = 0;
    nvalid = 0;
    for (int c = 0; c < max_cyc && !a_done; c++) begin
      a_ready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (a_valid) begin
        nvalid++;
        if (q.size() == 0) begin
          check({tag, "_extra_beat"}, 64'(1), 64'(0));
        end else begin
          e = q[0];
          check({tag, "_idx"}, 64'(a_idx), 64'(e.idx));
          check({tag, "_data"}, 64'(a_data), 64'(e.data));
          if (a_ready) begin
            void'(q.pop_front());
            nxfer++;
          end
        end
      end
      @(negedge clk);
    end
    a_ready = 1'b0;
    check({tag, "_done_seen"}, 64'(a_done), 64'(1));
    check({tag, "_sb_left"}, 64'(q.size()), 64'(0));
  endtask

  initial begin
    int  nx, nv;
    bit  hit;
    rst = 1'b1;
    a_start = 1'b0; a_ready = 1'b0; a_pc = 32'h0;
    b_start = 1'b0; b_ready = 1'b1; b_pc = 32'h0;
    fill_rf();
    repeat (3) @(negedge clk);

    // reset state
    check("rst_valid", 64'(a_valid), 64'(0));
    check("rst_busy", 64'(a_busy), 64'(0));
    check("rst_done", 64'(a_done), 64'(0));
    check("rst_timeout", 64'(a_timeout), 64'(0));
    check("rst_cc", 64'(a_cc), 64'(0));
    check("rst_idx", 64'(a_idx), 64'(0));
    check("rst_data", 64'(a_data), 64'(0));
    check("rst_addr", 64'(a_addr), 64'(0));
    rst = 1'b0;

    // halt loop: pc steps to 0x40 then holds
    @(negedge clk); a_pc = 32'h0; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    for (int k = 1; k <= 60 && !a_valid; k++) begin
      a_pc = (k <= 16) ? 32'(4 * k) : 32'h40;
      if (k == 5) begin
        check("t1_busy_run", 64'(a_busy), 64'(1));
        check("t1_done_run", 64'(a_done), 64'(0));
      end
      @(negedge clk);
    end
    check("t1_valid", 64'(a_valid), 64'(1));
    check("t1_cc", 64'(a_cc), 64'(20));
    check("t1_timeout", 64'(a_timeout), 64'(0));
    push_full(32'h40);
    drain_a("t1", 1'b0, 200, nx, nv);
    check("t1_xfers", 64'(nx), 64'(33));
    check("t1_valid_cycles", 64'(nv), 64'(33));
    check("t1_busy_fin", 64'(a_busy), 64'(0));
    check("t1_timeout_fin", 64'(a_timeout), 64'(0));

    // timeout with stalled consumer; a stray start mid-run is ignored
    @(negedge clk);
    check("t2_done_sticky", 64'(a_done), 64'(1));
    a_pc = 32'h1000; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    check("t2_done_clr", 64'(a_done), 64'(0));
    for (int k = 1; k <= 150 && !a_valid; k++) begin
      a_pc = 32'h1000 + 32'(4 * k);
      a_start = (k == 50);
      @(negedge clk);
    end
    a_start = 1'b0;
    check("t2_valid", 64'(a_valid), 64'(1));
    check("t2_cc", 64'(a_cc), 64'(100));
    check("t2_timeout", 64'(a_timeout), 64'(1));
    push_full(32'h1190);
    drain_a("t2", 1'b1, 400, nx, nv);
    check("t2_xfers", 64'(nx), 64'(33));
    check("t2_timeout_fin", 64'(a_timeout), 64'(1));
    check("t2_done_fin", 64'(a_done), 64'(1));

    // reset during the 10th register beat, then a clean dump
    @(negedge clk); a_pc = 32'h200; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    for (int c = 0; c < 20 && !a_valid; c++) @(negedge clk);
    check("t4_valid", 64'(a_valid), 64'(1));
    check("t4_cc", 64'(a_cc), 64'(4));
    a_ready = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      if (a_valid && (a_idx == 8'd9)) begin
        hit = 1'b1;
        rst = 1'b1;
      end
      @(negedge clk);
    end
    check("t4_hit_idx9", 64'(hit), 64'(1));
    check("t4_valid_rst", 64'(a_valid), 64'(0));
    check("t4_busy_rst", 64'(a_busy), 64'(0));
    check("t4_done_rst", 64'(a_done), 64'(0));
    check("t4_cc_rst", 64'(a_cc), 64'(0));
    rst = 1'b0; a_ready = 1'b0;
    @(negedge clk); a_pc = 32'h300; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    for (int c = 0; c < 20 && !a_valid; c++) @(negedge clk);
    check("t4b_valid", 64'(a_valid), 64'(1));
    push_full(32'h300);
    drain_a("t4b", 1'b0, 200, nx, nv);
    check("t4b_xfers", 64'(nx), 64'(33));

    // sparse register file: only $v0 and $t0 nonzero
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[2] = 32'd3;
    rf[8] = 32'd7;
    @(negedge clk); a_pc = 32'h500; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    for (int c = 0; c < 20 && !a_valid; c++) @(negedge clk);
    check("t5_valid", 64'(a_valid), 64'(1));
`ifdef MON_SKIP_ZERO_EN
    q.delete();
    push_beat(8'd32, 32'h500);
    push_beat(8'd2, 32'd3);
    push_beat(8'd8, 32'd7);
    drain_a("t5", 1'b0, 200, nx, nv);
    check("t5_xfers", 64'(nx), 64'(3));
`else
    push_full(32'h500);
    drain_a("t5", 1'b0, 200, nx, nv);
    check("t5_xfers", 64'(nx), 64'(33));
`endif

    // halt and timeout coincide on the second instance
    fill_rf();
    @(negedge clk); b_pc = 32'h80; b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    for (int c = 0; c < 20 && !b_valid; c++) @(negedge clk);
    check("t6_valid", 64'(b_valid), 64'(1));
    check("t6_cc", 64'(b_cc), 64'(4));
    check("t6_timeout", 64'(b_timeout), 64'(0));
    check("t6_pc_idx", 64'(b_idx), 64'(32));
    check("t6_pc_data", 64'(b_data), 64'(32'h80));
    for (int c = 0; c < 80 && !b_done; c++) @(negedge clk);
    check("t6_done", 64'(b_done), 64'(1));
    check("t6_timeout_fin", 64'(b_timeout), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
